// File: rtl/regfile_pkg.sv
// Shared sizing, types and reset value for the datapath register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned ADDR_W_DEFAULT = 3;
    localparam int unsigned NUM_REGS       = 2 ** ADDR_W_DEFAULT;

    typedef logic [ADDR_W_DEFAULT-1:0] reg_addr_t;
    typedef logic [DATA_W_DEFAULT-1:0] reg_data_t;

    localparam reg_data_t RESET_VALUE = '0;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: N:1 mux over the register array.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the addressed entry is forwarded.
module register_file_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  read_addr,
    input  logic                               rst,
    input  logic                               we,
    input  logic [ADDR_W-1:0]                  write_addr,
    input  logic [DATA_W-1:0]                  write_data,
    output logic [DATA_W-1:0]                  read_data
);

`ifdef REGFILE_BYPASS_EN
    logic w_fwd;
    assign w_fwd = we && !rst && (read_addr == write_addr);

    always_comb begin
        read_data = regs[read_addr];
        if (w_fwd) begin
            read_data = write_data;
        end
    end
`else
    // Write-side inputs only matter for forwarding.
    logic w_unused;
    assign w_unused = ^{rst, we, write_addr, write_data};

    always_comb begin
        read_data = regs[read_addr];
    end
`endif

endmodule

// File: rtl/register_file.sv
// 2**ADDR_W x DATA_W register file: two async read ports, one sync write port, sync reset.
// Optional write-to-read forwarding on both ports when REGFILE_BYPASS_EN is defined.
module register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    logic [(2**ADDR_W)-1:0][DATA_W-1:0] r_regs;

    // Reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= '{default: DATA_W'(RESET_VALUE)};
        end else if (we) begin
            r_regs[write_addr] <= write_data;
        end
    end

    register_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port1 (
        .regs       (r_regs),
        .read_addr  (read_addr1),
        .rst        (rst),
        .we         (we),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_data  (read_data1)
    );

    register_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port2 (
        .regs       (r_regs),
        .read_addr  (read_addr2),
        .rst        (rst),
        .we         (we),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_data  (read_data2)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (both REGFILE_BYPASS_EN builds).
module tb_register_file;

    logic       clk;
    logic       rst;
    logic       we;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic [2:0] read_addr1;
    logic [2:0] read_addr2;
    logic [7:0] read_data1;
    logic [7:0] read_data2;

    int n_compared;
    int n_mismatched;

    register_file #(
        .DATA_W (8),
        .ADDR_W (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        we         = 1'b1;
        write_addr = a;
        write_data = d;
        tick();
        we         = 1'b0;
    endtask

    logic [7:0] pat [8];

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        we           = 1'b0;
        write_addr   = '0;
        write_data   = '0;
        read_addr1   = '0;
        read_addr2   = '0;
        pat          = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78};

        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_addr1 = 3'(i);
            read_addr2 = 3'(7 - i);
            #1;
            check_eq($sformatf("reset_rd1[%0d]", i), read_data1, 8'h00);
            check_eq($sformatf("reset_rd2[%0d]", 7 - i), read_data2, 8'h00);
        end

        write_reg(3'd0, 8'h55);
        read_addr1 = 3'd0;
        read_addr2 = 3'd0;
        #1;
        check_eq("wr0_rd1", read_data1, 8'h55);
        check_eq("wr0_rd2", read_data2, 8'h55);

        write_reg(3'd1, 8'hAA);
        read_addr1 = 3'd1;
        read_addr2 = 3'd0;
        #1;
        check_eq("wr1_rd1", read_data1, 8'hAA);
        check_eq("wr1_rd2_reg0", read_data2, 8'h55);

        we         = 1'b0;
        write_addr = 3'd1;
        write_data = 8'h00;
        tick();
        check_eq("we0_hold", read_data1, 8'hAA);

        write_reg(3'd2, 8'h11);
        we         = 1'b1;
        write_addr = 3'd2;
        write_data = 8'h3C;
        read_addr1 = 3'd2;
        read_addr2 = 3'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("rdw_before", read_data1, 8'h3C);
`else
        check_eq("rdw_before", read_data1, 8'h11);
`endif
        check_eq("rdw_other_port", read_data2, 8'h55);
        tick();
        we = 1'b0;
        #1;
        check_eq("rdw_after", read_data1, 8'h3C);

        // Distinct value in every entry, read back through both ports.
        for (int i = 0; i < 8; i++) write_reg(3'(i), pat[i]);
        for (int i = 0; i < 8; i++) begin
            read_addr1 = 3'(i);
            read_addr2 = 3'((i + 3) % 8);
            #1;
            check_eq($sformatf("pat_rd1[%0d]", i), read_data1, pat[i]);
            check_eq($sformatf("pat_rd2[%0d]", (i + 3) % 8), read_data2, pat[(i + 3) % 8]);
        end

        rst        = 1'b1;
        we         = 1'b1;
        write_addr = 3'd5;
        write_data = 8'hFF;
        read_addr1 = 3'd5;
        #1;
        check_eq("rst_no_fwd", read_data1, pat[5]);
        tick();
        rst = 1'b0;
        we  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_addr1 = 3'(i);
            read_addr2 = 3'(i);
            #1;
            check_eq($sformatf("rstprio_rd1[%0d]", i), read_data1, 8'h00);
            check_eq($sformatf("rstprio_rd2[%0d]", i), read_data2, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
